// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard between decode and issue: stalls on RAW, WAW and
// MUL/DIV structural hazards. Define HAZARD_STATS_EN to add stall / load-use event counters.
module hazard_scoreboard #(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ALU_LAT  = 1,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned MD_LAT   = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_branch,
    input  logic [REG_W-1:0] id_dest,
    input  logic [1:0]       id_kind,
    input  logic             flush,
    output logic             stall,
    output logic [NREGS-1:0] busy_mask,
    output logic             md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      loaduse_events
`endif
);

    localparam logic [1:0] KindNone = 2'd0;
    localparam logic [1:0] KindAlu  = 2'd1;
    localparam logic [1:0] KindLoad = 2'd2;
    localparam logic [1:0] KindMd   = 2'd3;

    function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] kind);
        logic [CNT_W-1:0] lat;
        unique case (kind)
            KindAlu:  lat = CNT_W'(ALU_LAT);
            KindLoad: lat = CNT_W'(LOAD_LAT);
            KindMd:   lat = CNT_W'(MD_LAT);
            default:  lat = '0;
        endcase
        return lat;
    endfunction

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic [CNT_W-1:0] rs_cnt, rt_cnt, dest_cnt, dest_lat;
    logic             rs_ready, rt_ready;
    logic             raw, waw, md_struct, hazard, issue;

    always_comb begin
        rs_cnt   = cnt_q[id_rs];
        rt_cnt   = cnt_q[id_rt];
        dest_cnt = cnt_q[id_dest];
        dest_lat = lat_of(id_kind);

        // Non-branch consumers pick up the final cycle through EX forwarding; branches compare
        // in ID and need the value already written back.
        rs_ready = !id_use_rs || (id_rs == '0) ||
                   (id_is_branch ? (rs_cnt == '0) : (rs_cnt <= CNT_W'(1)));
        rt_ready = !id_use_rt || (id_rt == '0) ||
                   (id_is_branch ? (rt_cnt == '0) : (rt_cnt <= CNT_W'(1)));

        raw       = id_valid && !(rs_ready && rt_ready);
        waw       = id_valid && (id_dest != '0) && (dest_cnt > dest_lat);
        md_struct = id_valid && (id_kind == KindMd) && (md_cnt_q > CNT_W'(1));
        hazard    = raw || waw || md_struct;

        stall = hazard && !flush && reset_n;
        issue = id_valid && !hazard && !flush && reset_n;
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (issue && (id_dest == REG_W'(r)) && (id_kind != KindNone)) begin
                cnt_d[r] = dest_lat;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    // A MUL/DIV issue occupies the unit even when its result is discarded (dest 0).
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (issue && (id_kind == KindMd)) begin
            md_cnt_d = CNT_W'(MD_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
            md_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            md_cnt_q <= md_cnt_d;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 1; r < NREGS; r++) begin
            busy_mask[r] = (cnt_q[r] != '0);
        end
    end

    assign md_busy = (md_cnt_q != '0);

`ifdef HAZARD_STATS_EN
    logic [1:0]  kind_q [NREGS];
    logic [1:0]  kind_d [NREGS];
    logic        stall_q;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] loaduse_q, loaduse_d;
    logic        rs_load_block, rt_load_block, loaduse_hit;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            kind_d[r] = kind_q[r];
            if (r == 0) begin
                kind_d[r] = KindNone;
            end else if (issue && (id_dest == REG_W'(r)) && (id_kind != KindNone)) begin
                kind_d[r] = id_kind;
            end
        end

        // A source that is not ready always has a nonzero count, so its recorded kind is live.
        rs_load_block = !rs_ready && (kind_q[id_rs] == KindLoad);
        rt_load_block = !rt_ready && (kind_q[id_rt] == KindLoad);
        loaduse_hit   = stall && !stall_q && (rs_load_block || rt_load_block);

        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        loaduse_d = loaduse_q;
        if (loaduse_hit && (loaduse_q != '1)) begin
            loaduse_d = loaduse_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                kind_q[r] <= KindNone;
            end
            stall_q        <= 1'b0;
            stall_cycles_q <= '0;
            loaduse_q      <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                kind_q[r] <= kind_d[r];
            end
            stall_q        <= stall;
            stall_cycles_q <= stall_cycles_d;
            loaduse_q      <= loaduse_d;
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign loaduse_events = loaduse_q;
`endif

endmodule
